// File: rtl/ysyx_24090010_lsu_pkg.sv
// Shared types and decode helpers for the ysyx_24090010 load/store unit.
package ysyx_24090010_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] encodes the access size for every legal load and store.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic lsu_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_24090010_lsu_align.sv
// Byte-lane steering: store mask/replication and load extraction/extension.
module ysyx_24090010_lsu_align
  import ysyx_24090010_lsu_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfwords are only ever extracted at offset 0 or 2, so off[1] picks the lane.
  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  // Store byte enables and lane-replicated write data.
  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_func3)
      F3_SB: begin
        o_wmask = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_SH: begin
        o_wmask = 4'b0011 << i_off;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_SW: begin
        o_wmask = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_wmask = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load data sign/zero extension.
  always_comb begin
    o_rdata = 32'h0000_0000;
    case (i_func3)
      F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_rdata = {24'h00_0000, w_byte};
      F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_rdata = {16'h0000, w_half};
      F3_LW:   o_rdata = i_rdata;
      default: o_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/ysyx_24090010_lsu.sv
// Load/store unit: accepts one op from execute, runs it on the memory bus,
// and returns a single registered writeback beat.
module ysyx_24090010_lsu
  import ysyx_24090010_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [2:0]        in_func3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_wen,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              lsu_err
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;

  logic              r_is_store;
  logic [2:0]        r_func3;
  logic [1:0]        r_off;
  logic [4:0]        r_rd;

  logic              r_req_valid, w_req_valid_nxt;
  logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
  logic              r_wen,       w_wen_nxt;
  logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
  logic [3:0]        r_wmask,     w_wmask_nxt;
  logic              r_wb_valid,  w_wb_valid_nxt;
  logic              r_wb_wen,    w_wb_wen_nxt;
  logic [4:0]        r_wb_rd,     w_wb_rd_nxt;
  logic [DATA_W-1:0] r_wb_data,   w_wb_data_nxt;
  logic              r_err,       w_err_nxt;

  logic              w_idle;
  logic              w_ok;
  logic              w_load_wen;
  logic [2:0]        w_al_func3;
  logic [1:0]        w_al_off;
  logic [3:0]        w_wmask;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_load_ext;

  assign w_idle     = (r_state == S_IDLE);
  assign in_ready   = w_idle;
  assign w_ok       = lsu_legal(in_is_store, in_func3) &&
                      !lsu_misaligned(in_func3, in_addr[1:0]);
  assign w_load_wen = !r_is_store && (r_rd != 5'd0);

  // In IDLE the aligner sees the incoming op (store path); afterwards the latched op (load path).
  assign w_al_func3 = w_idle ? in_func3     : r_func3;
  assign w_al_off   = w_idle ? in_addr[1:0] : r_off;

  ysyx_24090010_lsu_align u_align (
    .i_func3 (w_al_func3),
    .i_off   (w_al_off),
    .i_wdata (in_wdata),
    .i_rdata (mem_rdata),
    .o_wmask (w_wmask),
    .o_wdata (w_wdata_rep),
    .o_rdata (w_load_ext)
  );

  assign mem_req_valid = r_req_valid;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;
  assign wb_valid      = r_wb_valid;
  assign wb_reg_wen    = r_wb_wen;
  assign wb_rd         = r_wb_rd;
  assign wb_data       = r_wb_data;
  assign lsu_err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = w_ok ? S_REQ : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus fields hold by default; writeback fields are single-cycle and default to zero.
  always_comb begin
    w_req_valid_nxt = r_req_valid;
    w_addr_nxt      = r_addr;
    w_wen_nxt       = r_wen;
    w_wdata_nxt     = r_wdata;
    w_wmask_nxt     = r_wmask;
    w_wb_valid_nxt  = 1'b0;
    w_wb_wen_nxt    = 1'b0;
    w_wb_rd_nxt     = 5'd0;
    w_wb_data_nxt   = {DATA_W{1'b0}};
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_ok) begin
          w_req_valid_nxt = 1'b1;
          w_addr_nxt      = {in_addr[ADDR_W-1:2], 2'b00};
          w_wen_nxt       = in_is_store;
          w_wdata_nxt     = in_is_store ? w_wdata_rep : {DATA_W{1'b0}};
          w_wmask_nxt     = in_is_store ? w_wmask : 4'b0000;
        end else if (in_valid) begin
          w_wb_valid_nxt  = 1'b1;
          w_err_nxt       = 1'b1;
          w_wb_rd_nxt     = in_rd;
        end else begin
          w_req_valid_nxt = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_req_valid_nxt = 1'b0;
          w_addr_nxt      = {ADDR_W{1'b0}};
          w_wen_nxt       = 1'b0;
          w_wdata_nxt     = {DATA_W{1'b0}};
          w_wmask_nxt     = 4'b0000;
        end else begin
          w_req_valid_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          w_wb_valid_nxt = 1'b1;
          w_wb_wen_nxt   = w_load_wen;
          w_wb_rd_nxt    = r_rd;
          w_wb_data_nxt  = w_load_wen ? w_load_ext : {DATA_W{1'b0}};
        end else begin
          w_wb_valid_nxt = 1'b0;
        end
      end
      S_DONE: begin
        w_wb_valid_nxt = 1'b0;
      end
      default: begin
        w_req_valid_nxt = 1'b0;
        w_addr_nxt      = {ADDR_W{1'b0}};
        w_wen_nxt       = 1'b0;
        w_wdata_nxt     = {DATA_W{1'b0}};
        w_wmask_nxt     = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_valid <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_wen       <= 1'b0;
      r_wdata     <= {DATA_W{1'b0}};
      r_wmask     <= 4'b0000;
      r_wb_valid  <= 1'b0;
      r_wb_wen    <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= {DATA_W{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_req_valid <= w_req_valid_nxt;
      r_addr      <= w_addr_nxt;
      r_wen       <= w_wen_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wmask     <= w_wmask_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_wen    <= w_wb_wen_nxt;
      r_wb_rd     <= w_wb_rd_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // The accepted op is kept for the load extraction and writeback that follow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_store <= 1'b0;
      r_func3    <= 3'b000;
      r_off      <= 2'b00;
      r_rd       <= 5'd0;
    end else if (in_valid && w_idle) begin
      r_is_store <= in_is_store;
      r_func3    <= in_func3;
      r_off      <= in_addr[1:0];
      r_rd       <= in_rd;
    end else begin
      r_is_store <= r_is_store;
      r_func3    <= r_func3;
      r_off      <= r_off;
      r_rd       <= r_rd;
    end
  end

endmodule

// File: tb/tb_ysyx_24090010_lsu.sv
// Self-checking bench for ysyx_24090010_lsu: directed plan plus randomized ops.
module tb_ysyx_24090010_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_func3 = 3'b000;
  logic [31:0] in_addr = 32'h0;
  logic [31:0] in_wdata = 32'h0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        wb_valid;
  logic        wb_reg_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24090010_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_func3(in_func3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_reg_wen(wb_reg_wen), .wb_rd(wb_rd),
    .wb_data(wb_data), .lsu_err(lsu_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, legality, and lane arithmetic.
  function automatic int ref_size(input bit [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit ref_ok(input bit st, input bit [2:0] f3, input bit [31:0] addr);
    bit legal;
    legal = st ? (int'(f3) <= 2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return legal && ((addr % ref_size(f3)) == 0);
  endfunction

  function automatic bit [31:0] ref_mask(input bit [2:0] f3, input bit [31:0] addr);
    int sz = ref_size(f3);
    return ((32'd1 << sz) - 32'd1) << (addr % 4);
  endfunction

  function automatic bit [31:0] ref_sdata(input bit [2:0] f3, input bit [31:0] wd);
    int sz = ref_size(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    else return wd;
  endfunction

  function automatic bit [31:0] ref_load(input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] word);
    int sz = ref_size(f3);
    longint v;
    v = (longint'(word) >> (8 * (addr % 4))) & ((longint'(1) << (8 * sz)) - 1);
    if (int'(f3) < 4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic run_op(input bit st, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, input bit [4:0] rd, input bit [31:0] word,
                        input int req_dly, input int rsp_dly);
    bit ok;
    bit exp_wen;
    ok = ref_ok(st, f3, addr);
    exp_wen = ok && !st && (rd != 5'd0);
    chk("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_is_store = st; in_func3 = f3; in_addr = addr;
    in_wdata = wd; in_rd = rd;
    tick();
    in_valid = 1'b0; in_wdata = $urandom; in_addr = $urandom;
    if (!ok) begin
      chk("err_no_req", mem_req_valid, 1'b0);
      chk("err_wb_valid", wb_valid, 1'b1);
      chk("err_lsu_err", lsu_err, 1'b1);
      chk("err_reg_wen", wb_reg_wen, 1'b0);
      chk("err_wb_data", wb_data, 32'h0);
    end else begin
      for (int i = 0; i <= req_dly; i++) begin
        chk("req_valid", mem_req_valid, 1'b1);
        chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk("req_wen", mem_wen, st);
        chk("req_wmask", mem_wmask, st ? ref_mask(f3, addr) : 32'h0);
        if (st) chk("req_wdata", mem_wdata, ref_sdata(f3, wd));
        chk("req_in_ready", in_ready, 1'b0);
        chk("req_no_wb", wb_valid, 1'b0);
        mem_req_ready = (i == req_dly);
        tick();
      end
      mem_req_ready = 1'b0;
      chk("wait_req_drop", mem_req_valid, 1'b0);
      for (int i = 0; i < rsp_dly; i++) begin
        chk("wait_no_wb", wb_valid, 1'b0);
        chk("wait_in_ready", in_ready, 1'b0);
        tick();
      end
      mem_rsp_valid = 1'b1; mem_rdata = word;
      tick();
      mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      chk("done_wb_valid", wb_valid, 1'b1);
      chk("done_lsu_err", lsu_err, 1'b0);
      chk("done_reg_wen", wb_reg_wen, exp_wen);
      chk("done_wb_data", wb_data, exp_wen ? ref_load(f3, addr, word) : 32'h0);
      if (exp_wen) chk("done_wb_rd", wb_rd, rd);
    end
    tick();
    chk("single_wb_beat", wb_valid, 1'b0);
    chk("back_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_wmask", mem_wmask, 4'h0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_lsu_err", lsu_err, 1'b0);
    rst_n = 1'b1;
    tick();

    run_op(1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd7, 32'h0, 0, 0);
    run_op(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 5'd7, 32'h0, 0, 0);
    run_op(1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd10, 32'h80FF_7F01, 0, 0);
    run_op(1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd10, 32'h80FF_7F01, 0, 0);
    run_op(1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd10, 32'h80FF_7F01, 0, 0);
    run_op(1'b0, 3'b101, 32'h8000_0000, 32'h0, 5'd10, 32'h80FF_7F01, 0, 0);
    run_op(1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd10, 32'h1234_5678, 0, 0);
    run_op(1'b0, 3'b011, 32'h8000_0000, 32'h0, 5'd10, 32'h1234_5678, 0, 0);
    run_op(1'b0, 3'b010, 32'h8000_0008, 32'h0, 5'd0, 32'h1234_5678, 0, 0);
    run_op(1'b1, 3'b001, 32'h8000_0006, 32'hCAFE_1234, 5'd3, 32'h0, 5, 3);

    for (int n = 0; n < 60; n++) begin
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             {30'($urandom), 2'($urandom_range(0, 3))}, $urandom,
             5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    in_valid = 1'b1; in_is_store = 1'b0; in_func3 = 3'b010;
    in_addr = 32'h8000_0010; in_rd = 5'd9;
    tick();
    in_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_no_wb", wb_valid, 1'b0);
      chk("rstmid_in_ready", in_ready, 1'b1);
      chk("rstmid_req_valid", mem_req_valid, 1'b0);
      chk("rstmid_mem_addr", mem_addr, 32'h0);
      chk("rstmid_wb_data", wb_data, 32'h0);
      chk("rstmid_lsu_err", lsu_err, 1'b0);
      tick();
    end
    run_op(1'b0, 3'b000, 32'h8000_0001, 32'h0, 5'd10, 32'h0000_F000, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
